conv_layer_scheduler: RTL

Sequences one convLayerSingle datapath across up to MAX_FILTERS filters of a conv layer; LeNet layer 1 uses 6 filters.
For each filter it selects the filter, pulses the datapath reset, and waits the fixed CONV_CYCLES compute latency.
It then presents the stable outputConv as valid to a downstream buffer with valid/ready and holds it until accepted.
Sits between the layer-level control FSM and the convLayerSingle instance plus filter ROM mux.

---
 rtl/conv_layer_scheduler.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/conv_layer_scheduler.sv
// conv_layer_scheduler
//
// Purpose: steps a single convLayerSingle datapath through up to MAX_FILTERS
// filters of a conv layer. For each filter it selects the filter, holds the
// datapath in reset for one cycle, waits CONV_CYCLES clocks of compute, and
// then presents the datapath output to a downstream buffer with valid/ready.
// The result is held until the buffer accepts it.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous, active-high reset
//   start            one-cycle run request, sampled only while idle
//   cfg_num_filters  number of filters to run, latched on accepted start
//   busy             high in every state except idle
//   done             one-cycle pulse at the end of a run
//   conv_reset       reset for the convLayerSingle datapath
//   filter_sel       filter index for the filter ROM mux
//   out_valid        datapath output is stable and valid
//   out_ready        downstream accepts the presented output
//   out_filter_idx   filter index of the presented output
//   perf_stall_cycles (only with CONV_SCHED_PERF_EN) saturating count of
//                    cycles spent waiting on out_ready
//
// Optional feature macro: CONV_SCHED_PERF_EN

module conv_layer_scheduler #(
  parameter int MAX_FILTERS = 6,
  parameter int FILT_IDX_W  = 3,
  parameter int CONV_CYCLES = 1569,
  parameter int CNT_W       = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FILT_IDX_W-1:0] cfg_num_filters,
  output logic                  busy,
  output logic                  done,
  output logic                  conv_reset,
  output logic [FILT_IDX_W-1:0] filter_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FILT_IDX_W-1:0] out_filter_idx
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [31:0]           perf_stall_cycles
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [FILT_IDX_W-1:0] MAX_N   = FILT_IDX_W'(MAX_FILTERS);
  localparam logic [FILT_IDX_W-1:0] IDX_ONE = FILT_IDX_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(CONV_CYCLES - 1);

  logic [2:0]            state_q, state_d;
  logic [FILT_IDX_W-1:0] filter_sel_q, filter_sel_d;
  logic [FILT_IDX_W-1:0] num_q, num_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

`ifdef CONV_SCHED_PERF_EN
  logic [31:0] perf_q, perf_d;
`endif

  // Next-state logic. The counter is cleared in LOAD and compared exactly
  // against the last compute cycle, so it never needs to wrap.
  always_comb begin
    state_d      = state_q;
    filter_sel_d = filter_sel_q;
    num_d        = num_q;
    cnt_d        = cnt_q;
`ifdef CONV_SCHED_PERF_EN
    perf_d       = perf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d        = (cfg_num_filters > MAX_N) ? MAX_N : cfg_num_filters;
          filter_sel_d = '0;
`ifdef CONV_SCHED_PERF_EN
          perf_d       = '0;
`endif
          state_d      = (num_d == '0) ? S_FIN : S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          if (filter_sel_q == num_q - IDX_ONE) begin
            state_d = S_FIN;
          end else begin
            filter_sel_d = filter_sel_q + IDX_ONE;
            state_d      = S_LOAD;
          end
        end
`ifdef CONV_SCHED_PERF_EN
        else if (perf_q != 32'hFFFF_FFFF) begin
          perf_d = perf_q + 32'd1;
        end
`endif
      end
      S_FIN: begin
        filter_sel_d = '0;
        state_d      = S_IDLE;
      end
      default: begin
        state_d      = S_IDLE;
        filter_sel_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      filter_sel_q <= '0;
      num_q        <= '0;
      cnt_q        <= '0;
`ifdef CONV_SCHED_PERF_EN
      perf_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      filter_sel_q <= filter_sel_d;
      num_q        <= num_d;
      cnt_q        <= cnt_d;
`ifdef CONV_SCHED_PERF_EN
      perf_q       <= perf_d;
`endif
    end
  end

  // Outputs decode from state only, so out_ready never reaches out_valid
  // combinationally and an async reset forces them to idle values at once.
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_FIN);
  assign out_valid      = (state_q == S_HOLD);
  assign conv_reset     = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_FIN);
  assign filter_sel     = filter_sel_q;
  assign out_filter_idx = filter_sel_q;

`ifdef CONV_SCHED_PERF_EN
  assign perf_stall_cycles = perf_q;
`endif

endmodule
